interleaver_mm: RTL and testbench

Multi-mode serial bit interleaver for the WiMAX OFDM transmit chain, between the FEC encoder and the constellation mapper. Accepts one coded bit per cycle, permutes each block of Ncbps bits with the two-step 802.16 interleaver permutation, and streams the block out in interleaved order. Modulation (QPSK/16-QAM/64-QAM) is selected per block at run time. Ping-pong buffering sustains 1 bit/cycle.

---
 rtl/interleaver_mm_if.sv | 41 ++++
 rtl/interleaver_mm.sv | 221 ++++++++++++++++++++++
 tb/tb_interleaver_mm.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interleaver_mm_if.sv
// interleaver_mm_if: bit-stream handshake bundle for interleaver_mm.
// The write side (in_*) and the read side (out_*) each use valid/ready:
// a bit moves on a rising clk edge where valid and ready are both high.
// Valid never depends on ready, and the payload is held steady while
// valid is high and ready is low.
// With INTLV_DEINT_EN defined the bundle also carries the deint select.
interface interleaver_mm_if #(
  parameter int IDX_W = 10
) ();
  logic [1:0]       mod_sel;
  logic             in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic [1:0]       mod_out;
`ifdef INTLV_DEINT_EN
  logic             deint;

  modport master (
    output mod_sel, in_data, in_valid, deint, out_ready,
    input  in_ready, out_data, out_valid, out_index, out_last, mod_out
  );
  modport slave (
    input  mod_sel, in_data, in_valid, deint, out_ready,
    output in_ready, out_data, out_valid, out_index, out_last, mod_out
  );
`else
  modport master (
    output mod_sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_index, out_last, mod_out
  );
  modport slave (
    input  mod_sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_index, out_last, mod_out
  );
`endif
endinterface

// File: rtl/interleaver_mm.sv
// interleaver_mm: ping-pong 802.16 two-step bit interleaver, one bit per cycle.
// Write side scatters bit k to address jk of the fill bank; read side streams
// the full bank out sequentially through a 2-entry skid buffer.
// Optional macro INTLV_DEINT_EN: adds a per-block deint select that writes
// sequentially and reads at jk, producing the inverse permutation.
module interleaver_mm #(
  parameter int NSUB  = 96,
  parameter int D     = 16,
  parameter int IDX_W = $clog2(NSUB * 6)
) (
  input logic             clk,
  input logic             resetN,
  interleaver_mm_if.slave bus
);
  localparam int DEPTH = NSUB * 6;
  localparam int R_W   = (D > 1) ? $clog2(D) : 1;

  // Incremental position state: k, r = k mod D, q = k / D, rb = rows*r,
  // plus mod-3 residues of q, r and rb so 64-QAM needs no divider.
  typedef struct packed {
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] q;
    logic [IDX_W-1:0] rb;
    logic [R_W-1:0]   r;
    logic [1:0]       q3;
    logic [1:0]       r3;
    logic [1:0]       rb3;
  } cnt_t;

  typedef struct packed {
    logic             data;
    logic [IDX_W-1:0] index;
    logic             last;
    logic [1:0]       mode;
  } ent_t;

  function automatic int ncpc_of(input logic [1:0] m);
    case (m)
      2'd1:    return 4;
      2'd2:    return 6;
      default: return 2;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] last_of(input logic [1:0] m);
    return IDX_W'(NSUB * ncpc_of(m) - 1);
  endfunction

  function automatic logic [IDX_W-1:0] rows_of(input logic [1:0] m);
    return IDX_W'(NSUB * ncpc_of(m) / D);
  endfunction

  function automatic logic [1:0] rows3_of(input logic [1:0] m);
    return 2'((NSUB * ncpc_of(m) / D) % 3);
  endfunction

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [1:0] neg3(input logic [1:0] a);
    return (a == 2'd0) ? 2'd0 : 2'(2'd3 - a);
  endfunction

  function automatic cnt_t cnt_next(input cnt_t c, input logic [1:0] m);
    cnt_t n;
    n = c;
    if (c.k == last_of(m)) begin
      n = '0;
    end else begin
      n.k = c.k + 1'b1;
      if (c.r == R_W'(D - 1)) begin
        n.r   = '0;
        n.r3  = 2'd0;
        n.rb  = '0;
        n.rb3 = 2'd0;
        n.q   = c.q + 1'b1;
        n.q3  = mod3_add(c.q3, 2'd1);
      end else begin
        n.r   = c.r + 1'b1;
        n.r3  = mod3_add(c.r3, 2'd1);
        n.rb  = c.rb + rows_of(m);
        n.rb3 = mod3_add(c.rb3, rows3_of(m));
      end
    end
    return n;
  endfunction

  // jk = s*floor(mk/s) + ((mk - r) mod s); Ncbps is a multiple of s so it drops out.
  function automatic logic [IDX_W-1:0] perm(input cnt_t c, input logic [1:0] m);
    logic [IDX_W-1:0] mk;
    logic [1:0]       mk3;
    logic [1:0]       d3;
    mk  = c.rb + c.q;
    mk3 = mod3_add(c.rb3, c.q3);
    d3  = mod3_add(mk3, neg3(c.r3));
    case (m)
      2'd1:    return {mk[IDX_W-1:1], mk[0] ^ c.r[0]};
      2'd2:    return mk - IDX_W'(mk3) + IDX_W'(d3);
      default: return mk;
    endcase
  endfunction

  logic [DEPTH-1:0] mem [2];
  logic [1:0]       bank_mode [2];
  logic [1:0]       full;
  logic             wr_sel, rd_sel, iss_sel;
  cnt_t             wr_st, rd_st;
  ent_t             fifo [2];
  logic             f_wr, f_rd;
  logic [1:0]       f_cnt;

  logic [1:0]       sel_mode, wr_mode, iss_mode;
  logic             wr_fire, wr_last, issue, iss_last, pop, free_bank;
  logic [IDX_W-1:0] wr_addr, rd_addr;
  ent_t             head;
`ifdef INTLV_DEINT_EN
  logic [1:0]       bank_deint;
  logic             wr_deint;
`endif

  // Write-side decode: mode of the block being filled and the scatter address.
  always_comb begin
    sel_mode = (bus.mod_sel == 2'd3) ? 2'd0 : bus.mod_sel;
    wr_mode  = (wr_st.k == '0) ? sel_mode : bank_mode[wr_sel];
    wr_fire  = bus.in_valid && !full[wr_sel];
    wr_last  = (wr_st.k == last_of(wr_mode));
`ifdef INTLV_DEINT_EN
    wr_deint = (wr_st.k == '0) ? bus.deint : bank_deint[wr_sel];
    wr_addr  = wr_deint ? wr_st.k : perm(wr_st, wr_mode);
`else
    wr_addr  = perm(wr_st, wr_mode);
`endif
  end

  // Read-side decode: issue a bank read whenever the skid buffer will have room.
  always_comb begin
    iss_mode  = bank_mode[iss_sel];
    iss_last  = (rd_st.k == last_of(iss_mode));
    pop       = (f_cnt != 2'd0) && bus.out_ready;
    issue     = full[iss_sel] && ((f_cnt != 2'd2) || pop);
    free_bank = pop && head.last;
`ifdef INTLV_DEINT_EN
    rd_addr   = bank_deint[iss_sel] ? perm(rd_st, iss_mode) : rd_st.k;
`else
    rd_addr   = rd_st.k;
`endif
  end

  assign head          = fifo[f_rd];
  assign bus.in_ready  = !full[wr_sel];
  assign bus.out_valid = (f_cnt != 2'd0);
  assign bus.out_data  = head.data;
  assign bus.out_index = head.index;
  assign bus.out_last  = head.last;
  assign bus.mod_out   = head.mode;

  // Write-side counters, fill-bank pointer and per-bank mode latch.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_st        <= '0;
      wr_sel       <= 1'b0;
      bank_mode[0] <= 2'd0;
      bank_mode[1] <= 2'd0;
`ifdef INTLV_DEINT_EN
      bank_deint   <= 2'b00;
`endif
    end else if (wr_fire) begin
      if (wr_st.k == '0) begin
        bank_mode[wr_sel]  <= sel_mode;
`ifdef INTLV_DEINT_EN
        bank_deint[wr_sel] <= bus.deint;
`endif
      end
      wr_st <= cnt_next(wr_st, wr_mode);
      if (wr_last) wr_sel <= !wr_sel;
    end
  end

  // Bank storage; contents are only meaningful once the bank is marked full.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_sel][wr_addr] <= bus.in_data;
  end

  // Full flags: set by the last write of a block, cleared by the last output transfer.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      full <= 2'b00;
    end else begin
      if (wr_fire && wr_last) full[wr_sel] <= 1'b1;
      if (free_bank)          full[rd_sel] <= 1'b0;
    end
  end

  // Read issue, registered bank read into the skid buffer, and output pop.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_st   <= '0;
      iss_sel <= 1'b0;
      rd_sel  <= 1'b0;
      fifo[0] <= '0;
      fifo[1] <= '0;
      f_wr    <= 1'b0;
      f_rd    <= 1'b0;
      f_cnt   <= 2'd0;
    end else begin
      if (issue) begin
        fifo[f_wr] <= '{data: mem[iss_sel][rd_addr], index: rd_st.k,
                        last: iss_last, mode: iss_mode};
        f_wr       <= !f_wr;
        rd_st      <= cnt_next(rd_st, iss_mode);
        if (iss_last) iss_sel <= !iss_sel;
      end
      if (pop)       f_rd   <= !f_rd;
      if (free_bank) rd_sel <= !rd_sel;
      f_cnt <= 2'(f_cnt + {1'b0, issue} - {1'b0, pop});
    end
  end
endmodule

// File: tb/tb_interleaver_mm.sv
// tb_interleaver_mm: directed bench for interleaver_mm with a permutation
// model computed from the interleaver formula and a per-cycle scoreboard.
module tb_interleaver_mm;
  localparam int NSUB  = 96;
  localparam int D     = 16;
  localparam int IDX_W = $clog2(NSUB * 6);
  localparam int DEPTH = NSUB * 6;
  localparam int W     = IDX_W + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  interleaver_mm_if #(.IDX_W(IDX_W)) bus ();
  interleaver_mm #(.NSUB(NSUB), .D(D), .IDX_W(IDX_W)) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic         blk  [DEPTH];
  logic         orig [DEPTH];
  logic         cap  [DEPTH];
  int           ones_q[$];
  int           blocks_written = 0;
  int           blocks_read = 0;
  int           ready_mode = 0;
  int           stalls = 0;
  int           last_idx = -1;
  logic         cur_deint = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- model ----------------
  function automatic int blen(input int m);
    return NSUB * ((m == 1) ? 4 : (m == 2) ? 6 : 2);
  endfunction

  function automatic int perm_of(input int m, input int k);
    int n, s, r, mk;
    n  = blen(m);
    s  = n / NSUB / 2;
    r  = k % D;
    mk = (n / D) * r + k / D;
    return s * (mk / s) + (mk + n - r) % s;
  endfunction

  task automatic push_expected(input int m, input int n);
    logic         mdl [DEPTH];
    logic [W-1:0] e;
    int           mn;
    mn = (m == 3) ? 0 : m;
    for (int k = 0; k < n; k++) begin
      if (cur_deint) mdl[k] = blk[perm_of(mn, k)];
      else           mdl[perm_of(mn, k)] = blk[k];
    end
    for (int j = 0; j < n; j++) begin
      e = {2'(mn), (j == n - 1), IDX_W'(j), mdl[j]};
      exp_q.push_back(e);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b, input logic [1:0] m);
    int g;
    g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.mod_sel  = m;
`ifdef INTLV_DEINT_EN
    bus.deint    = cur_deint;
`endif
    while (!bus.in_ready && g < 5000) begin
      @(posedge clk); #1;
      g++;
      stalls++;
    end
    if (g >= 5000) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready 0 for %0d cycles, required 1", g);
    end
    @(posedge clk); #1;
  endtask

  // Mode is presented only on bit 0; later bits carry random mode noise.
  task automatic send_block(input int m, input int nbits);
    for (int k = 0; k < nbits; k++)
      send_bit(blk[k], (k == 0) ? 2'(m) : 2'($urandom_range(0, 3)));
    bus.in_valid = 1'b0;
    if (nbits == blen(m == 3 ? 0 : m)) blocks_written++;
  endtask

  task automatic fill_zero();
    for (int k = 0; k < DEPTH; k++) blk[k] = 1'b0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < DEPTH; k++) blk[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 20000) begin
      @(posedge clk);
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("blocks_balanced", blocks_read, blocks_written);
  endtask

  always @(posedge clk) begin
    #1;
    bus.out_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- scoreboard / compare ----------------
  logic [W-1:0] prev_word;
  logic         prev_stall = 1'b0;
  logic         prev_mid = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    if (!resetN) begin
      prev_stall = 1'b0;
      prev_mid   = 1'b0;
    end else begin
      got = {bus.mod_out, bus.out_last, bus.out_index, bus.out_data};
      chk("in_ready_vs_banks", bus.in_ready, (blocks_written - blocks_read) < 2);
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_hold", got, prev_word);
      end
      if (prev_mid) chk("no_gap_in_block", bus.out_valid, 1);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = got;
      prev_mid   = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h, required no output", got);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", got, e);
        end
        if (bus.out_data) ones_q.push_back(int'(bus.out_index));
        cap[bus.out_index] = bus.out_data;
        if (bus.out_last) begin
          blocks_read++;
          last_idx = int'(bus.out_index);
        end else begin
          prev_mid = 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: no finish within 80000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int mism;
    bus.in_valid  = 1'b0;
    bus.in_data   = 1'b0;
    bus.mod_sel   = 2'd0;
    bus.out_ready = 1'b0;
`ifdef INTLV_DEINT_EN
    bus.deint     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_index", bus.out_index, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_mod_out", bus.mod_out, 0);
    resetN = 1'b1;
    @(posedge clk); #1;

    // Hand-computed anchors for the model itself.
    chk("model_qpsk_k1", perm_of(0, 1), 12);
    chk("model_16qam_k1", perm_of(1, 1), 25);
    chk("model_64qam_k1", perm_of(2, 1), 38);
    chk("model_64qam_k2", perm_of(2, 2), 73);

    // QPSK single one at k=1, plus 2-cycle latency from the last input.
    fill_zero(); blk[1] = 1'b1; ones_q.delete();
    push_expected(0, 192);
    send_block(0, 192);
    chk("lat_cycle_t1", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("lat_cycle_t2", bus.out_valid, 1);
    chk("lat_first_index", bus.out_index, 0);
    wait_drain();
    chk("qpsk_ones_count", ones_q.size(), 1);
    chk("qpsk_one_index", (ones_q.size() > 0) ? ones_q[0] : -1, 12);
    chk("qpsk_last_index", last_idx, 191);

    // 16-QAM ones at k=0,1.
    fill_zero(); blk[0] = 1'b1; blk[1] = 1'b1; ones_q.delete();
    push_expected(1, 384);
    send_block(1, 384);
    wait_drain();
    chk("qam16_ones_count", ones_q.size(), 2);
    chk("qam16_one_a", (ones_q.size() > 1) ? ones_q[0] : -1, 0);
    chk("qam16_one_b", (ones_q.size() > 1) ? ones_q[1] : -1, 25);

    // 64-QAM ones at k=1,2.
    fill_zero(); blk[1] = 1'b1; blk[2] = 1'b1; ones_q.delete();
    push_expected(2, 576);
    send_block(2, 576);
    wait_drain();
    chk("qam64_ones_count", ones_q.size(), 2);
    chk("qam64_one_a", (ones_q.size() > 1) ? ones_q[0] : -1, 38);
    chk("qam64_one_b", (ones_q.size() > 1) ? ones_q[1] : -1, 73);
    chk("qam64_last_index", last_idx, 575);

    // Three back-to-back blocks, both sides always ready.
    stalls = 0;
    fill_random(); push_expected(0, 192); send_block(0, 192);
    fill_random(); push_expected(2, 576); send_block(2, 576);
    fill_random(); push_expected(1, 384); send_block(1, 384);
    wait_drain();
    chk("b2b_no_in_stall", stalls, 0);

    // Four blocks under random backpressure; mode 3 behaves as QPSK.
    ready_mode = 1;
    stalls = 0;
    fill_random(); push_expected(2, 576); send_block(2, 576);
    fill_random(); push_expected(2, 576); send_block(2, 576);
    fill_random(); push_expected(1, 384); send_block(1, 384);
    fill_random(); push_expected(3, 192); send_block(3, 192);
    wait_drain();
    chk("bp_in_ready_low_seen", stalls > 0, 1);

    // Reset while a block is draining and another is half written.
    fill_random(); push_expected(0, 192); send_block(0, 192);
    fill_random(); send_block(1, 60);
    resetN = 1'b0;
    #1;
    chk("rst2_in_ready", bus.in_ready, 1);
    chk("rst2_out_valid", bus.out_valid, 0);
    chk("rst2_out_data", bus.out_data, 0);
    chk("rst2_out_index", bus.out_index, 0);
    chk("rst2_out_last", bus.out_last, 0);
    chk("rst2_mod_out", bus.mod_out, 0);
    exp_q.delete();
    blocks_written = 0;
    blocks_read = 0;
    @(posedge clk); #1;
    resetN = 1'b1;
    ready_mode = 0;
    @(posedge clk); #1;
    fill_random(); push_expected(0, 192); send_block(0, 192);
    wait_drain();

`ifdef INTLV_DEINT_EN
    // Interleave a 64-QAM block, then deinterleave the captured output.
    cur_deint = 1'b0;
    fill_random();
    for (int k = 0; k < DEPTH; k++) orig[k] = blk[k];
    push_expected(2, 576); send_block(2, 576);
    wait_drain();
    for (int k = 0; k < DEPTH; k++) blk[k] = cap[k];
    cur_deint = 1'b1;
    push_expected(2, 576); send_block(2, 576);
    wait_drain();
    mism = 0;
    for (int k = 0; k < 576; k++) if (cap[k] !== orig[k]) mism++;
    chk("deint_roundtrip", mism, 0);
    cur_deint = 1'b0;
`else
    mism = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
